// File: rtl/hsl_pkg.sv
// Shared constants and types for the HSL <-> RGB colour-space blocks.
// Hue is coded as six sectors of HUE_SECTOR codes each. Channels are HSL_W
// bits on the HSL side and RGB_W bits on the VGA side.
package hsl_pkg;

  localparam int HUE_SECTOR = 128;
  localparam int HUE_MAX    = 6 * HUE_SECTOR;
  localparam int FRAC_W     = 7;      // log2(HUE_SECTOR)
  localparam int HSL_W      = 10;
  localparam int RGB_W      = 8;
  localparam int HSL_MAX    = (1 << HSL_W) - 1;

  // Hue sectors, named by the colours they run between
  typedef enum logic [2:0] {
    SEC_RY = 3'd0,  // red     -> yellow
    SEC_YG = 3'd1,  // yellow  -> green
    SEC_GC = 3'd2,  // green   -> cyan
    SEC_CB = 3'd3,  // cyan    -> blue
    SEC_BM = 3'd4,  // blue    -> magenta
    SEC_MR = 3'd5   // magenta -> red
  } sector_e;

endpackage

// File: rtl/hsl_to_rgb_if.sv
// Pixel stream bundle for the HSL -> RGB converter: an HSL valid/ready input
// stream and an RGB valid/ready output stream. The converter takes the slave
// view; the pixel source/sink side takes the master view.
interface hsl_to_rgb_if;
  import hsl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [HSL_W-1:0] iHue;
  logic [HSL_W-1:0] iSaturation;
  logic [HSL_W-1:0] iLightness;
  logic             out_valid;
  logic             out_ready;
  logic [RGB_W-1:0] oRed;
  logic [RGB_W-1:0] oGreen;
  logic [RGB_W-1:0] oBlue;

  modport slave (
    input  in_valid, iHue, iSaturation, iLightness, out_ready,
    output in_ready, out_valid, oRed, oGreen, oBlue
  );

  modport master (
    output in_valid, iHue, iSaturation, iLightness, out_ready,
    input  in_ready, out_valid, oRed, oGreen, oBlue
  );

endinterface

// File: rtl/hsl_sector_mux.sv
// Routes chroma C and secondary component X onto the r/g/b terms for the
// given hue sector. Purely combinational.
module hsl_sector_mux
  import hsl_pkg::*;
(
  input  sector_e          sector,
  input  logic [HSL_W-1:0] c,
  input  logic [HSL_W-1:0] x,
  output logic [HSL_W-1:0] r,
  output logic [HSL_W-1:0] g,
  output logic [HSL_W-1:0] b
);

  // Pick which channel gets C, which gets X and which stays at zero
  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (sector)
      SEC_RY: begin r = c; g = x; end
      SEC_YG: begin r = x; g = c; end
      SEC_GC: begin g = c; b = x; end
      SEC_CB: begin g = x; b = c; end
      SEC_BM: begin r = x; b = c; end
      SEC_MR: begin r = c; b = x; end
      default: ;
    endcase
  end

endmodule

// File: rtl/hsl_to_rgb.sv
// Three-stage pipelined HSL[10,10,10] -> RGB[8,8,8] converter with a
// valid/ready stream on both sides. A stalled output freezes the whole pipe.
// Build option: define HSL2RGB_ROUND_EN for round-half-up scaling instead of
// truncation; latency and handshake do not change.
module hsl_to_rgb
  import hsl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  hsl_to_rgb_if.slave px
);

  localparam int DW = HSL_W + 2;

  function automatic logic [HSL_W-1:0] scale_c(input logic [2*HSL_W-1:0] prod);
`ifdef HSL2RGB_ROUND_EN
    logic [2*HSL_W:0] sum;
    logic [HSL_W:0]   q;
    sum = {1'b0, prod} + (2*HSL_W+1)'(1 << (HSL_W - 1));
    q   = (HSL_W+1)'(sum >> HSL_W);
    return (q > (HSL_W+1)'(HSL_MAX)) ? HSL_W'(HSL_MAX) : q[HSL_W-1:0];
`else
    return HSL_W'(prod >> HSL_W);
`endif
  endfunction

  function automatic logic [HSL_W-1:0] scale_x(input logic [HSL_W+FRAC_W:0] prod);
`ifdef HSL2RGB_ROUND_EN
    logic [HSL_W+FRAC_W+1:0] sum;
    logic [HSL_W+1:0]        q;
    sum = {1'b0, prod} + (HSL_W+FRAC_W+2)'(1 << (FRAC_W - 1));
    q   = (HSL_W+2)'(sum >> FRAC_W);
    return (q > (HSL_W+2)'(HSL_MAX)) ? HSL_W'(HSL_MAX) : q[HSL_W-1:0];
`else
    return HSL_W'(prod >> FRAC_W);
`endif
  endfunction

  function automatic logic [RGB_W-1:0] to_rgb(input logic [HSL_W:0] ch);
    logic [HSL_W-1:0] sat;
`ifdef HSL2RGB_ROUND_EN
    logic [HSL_W:0] sum;
    logic [RGB_W:0] q;
`endif
    sat = (ch > (HSL_W+1)'(HSL_MAX)) ? HSL_W'(HSL_MAX) : ch[HSL_W-1:0];
`ifdef HSL2RGB_ROUND_EN
    sum = {1'b0, sat} + (HSL_W+1)'(1 << (HSL_W - RGB_W - 1));
    q   = (RGB_W+1)'(sum >> (HSL_W - RGB_W));
    return (q > (RGB_W+1)'((1 << RGB_W) - 1)) ? {RGB_W{1'b1}} : q[RGB_W-1:0];
`else
    return RGB_W'(sat >> (HSL_W - RGB_W));
`endif
  endfunction

  logic en;
  logic vld_p0, vld_p1, vld_p2;

  assign en          = !vld_p2 || px.out_ready;
  assign px.in_ready = en;
  assign px.out_valid = vld_p2;

  // ---- S1: hue wrap, sector split, chroma base from lightness ----
  logic [HSL_W-1:0]     hue_w;
  logic signed [DW-1:0] dl_w;
  logic [HSL_W:0]       dl_abs_w;
  logic [HSL_W-1:0]     cbase_w;

  assign hue_w    = (px.iHue >= HSL_W'(HUE_MAX)) ? px.iHue - HSL_W'(HUE_MAX) : px.iHue;
  assign dl_w     = $signed({1'b0, px.iLightness, 1'b0}) - $signed(DW'(HSL_MAX));
  assign dl_abs_w = dl_w[DW-1] ? (HSL_W+1)'($unsigned(-dl_w)) : (HSL_W+1)'($unsigned(dl_w));
  assign cbase_w  = HSL_W'((HSL_W+1)'(HSL_MAX) - dl_abs_w);

  sector_e           sector_p0;
  logic [FRAC_W-1:0] frac_p0;
  logic [HSL_W-1:0]  sat_p0, lit_p0, cbase_p0;

  // ---- S2: chroma scale and in-sector ramp direction ----
  logic [2*HSL_W-1:0] prod_c_w;
  logic [HSL_W-1:0]   c_w;
  logic [FRAC_W:0]    f_w;

  assign prod_c_w = cbase_p0 * sat_p0;
  assign c_w      = scale_c(prod_c_w);
  // Odd sectors ramp X downward as hue advances
  assign f_w = (sector_p0 inside {SEC_YG, SEC_CB, SEC_MR})
             ? (FRAC_W+1)'(HUE_SECTOR) - {1'b0, frac_p0}
             : {1'b0, frac_p0};

  sector_e          sector_p1;
  logic [HSL_W-1:0] c_p1, lit_p1;
  logic [FRAC_W:0]  f_p1;

  // ---- S3: secondary component, lightness offset, channel mapping ----
  logic [HSL_W+FRAC_W:0] prod_x_w;
  logic [HSL_W-1:0]      x_w, m_w, r_t, g_t, b_t;
  logic [RGB_W-1:0]      red_w, green_w, blue_w;

  assign prod_x_w = c_p1 * f_p1;
  assign x_w      = scale_x(prod_x_w);
  assign m_w      = lit_p1 - (c_p1 >> 1);

  hsl_sector_mux u_mux (
    .sector (sector_p1),
    .c      (c_p1),
    .x      (x_w),
    .r      (r_t),
    .g      (g_t),
    .b      (b_t)
  );

  assign red_w   = to_rgb({1'b0, m_w} + {1'b0, r_t});
  assign green_w = to_rgb({1'b0, m_w} + {1'b0, g_t});
  assign blue_w  = to_rgb({1'b0, m_w} + {1'b0, b_t});

  logic [RGB_W-1:0] red_p2, green_p2, blue_p2;

  assign px.oRed   = red_p2;
  assign px.oGreen = green_p2;
  assign px.oBlue  = blue_p2;

  // Valid bits shift with the pipe; reset drops every in-flight pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= px.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Internal datapath registers advance together; no reset needed
  always_ff @(posedge clk) begin
    if (en) begin
      // S1 -> p0
      sector_p0 <= sector_e'(hue_w[HSL_W-1:FRAC_W]);
      frac_p0   <= hue_w[FRAC_W-1:0];
      sat_p0    <= px.iSaturation;
      lit_p0    <= px.iLightness;
      cbase_p0  <= cbase_w;
      // S2 -> p1
      sector_p1 <= sector_p0;
      c_p1      <= c_w;
      f_p1      <= f_w;
      lit_p1    <= lit_p0;
    end
  end

  // Output pixel register, cleared on reset so the VGA side sees black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_p2   <= '0;
      green_p2 <= '0;
      blue_p2  <= '0;
    end else if (en) begin
      // S3 -> p2
      red_p2   <= red_w;
      green_p2 <= green_w;
      blue_p2  <= blue_w;
    end
  end

endmodule

// File: tb/tb_hsl_to_rgb.sv
// Self-checking bench for hsl_to_rgb: scoreboard of expected RGB triples
// pushed on acceptance and popped when the converter hands a pixel out.
// Honours HSL2RGB_ROUND_EN the same way as the design.
module tb_hsl_to_rgb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hsl_to_rgb_if bus ();

  hsl_to_rgb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .px    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_rx     = 0;
  logic [23:0] sb_q[$];
  logic [23:0] mon_exp;
  bit rnd_done;

  function automatic logic [7:0] chan(input int v);
    int t;
    t = (v > 1023) ? 1023 : v;
`ifdef HSL2RGB_ROUND_EN
    t = (t + 2) / 4;
    if (t > 255) t = 255;
`else
    t = t / 4;
`endif
    return 8'(t);
  endfunction

  function automatic logic [23:0] model(input int h, input int s, input int l);
    int hh, sec, frac, cb, d, c, f, x, m, tr, tg, tbl;
    hh   = (h >= 768) ? h - 768 : h;
    sec  = hh / 128;
    frac = hh % 128;
    d    = 2 * l - 1023;
    cb   = 1023 - ((d < 0) ? -d : d);
`ifdef HSL2RGB_ROUND_EN
    c = (cb * s + 512) / 1024;
    if (c > 1023) c = 1023;
`else
    c = (cb * s) / 1024;
`endif
    f = (sec % 2 == 1) ? 128 - frac : frac;
`ifdef HSL2RGB_ROUND_EN
    x = (c * f + 64) / 128;
`else
    x = (c * f) / 128;
`endif
    m = l - c / 2;
    tr = 0; tg = 0; tbl = 0;
    case (sec)
      0: begin tr = c; tg = x; end
      1: begin tr = x; tg = c; end
      2: begin tg = c; tbl = x; end
      3: begin tg = x; tbl = c; end
      4: begin tr = x; tbl = c; end
      default: begin tr = c; tbl = x; end
    endcase
    return {chan(m + tr), chan(m + tg), chan(m + tbl)};
  endfunction

  function automatic logic [23:0] pick(input logic [23:0] e_def, input logic [23:0] e_rnd);
`ifdef HSL2RGB_ROUND_EN
    return e_rnd;
`else
    return e_def;
`endif
  endfunction

  // Scoreboard pop: a pixel leaves on the next edge when valid and ready
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h, scoreboard empty", {bus.oRed, bus.oGreen, bus.oBlue});
      end else begin
        mon_exp = sb_q.pop_front();
        n_rx++;
        if ({bus.oRed, bus.oGreen, bus.oBlue} !== mon_exp) begin
          n_fail++;
          $display("FAIL out_pixel: got %h, expected %h", {bus.oRed, bus.oGreen, bus.oBlue}, mon_exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d pixels pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  task automatic set_px(input int h, input int s, input int l);
    bus.iHue        = 10'(h);
    bus.iSaturation = 10'(s);
    bus.iLightness  = 10'(l);
    bus.in_valid    = 1'b1;
  endtask

  task automatic send_px(input int h, input int s, input int l, input logic [23:0] exp, input string tag);
    bit acc = 1'b0;
    set_px(h, s, l);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb_q.push_back(exp);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept_timeout: in_ready stayed low, required an accept", tag);
    end
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2000 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d pixels still outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_valid: out_valid=%b after drain, required 0", tag, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.iHue = '0; bus.iSaturation = '0; bus.iLightness = '0;
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: out_valid=%b, required 0", bus.out_valid);
    end
    n_checks++;
    if ({bus.oRed, bus.oGreen, bus.oBlue} !== 24'h0) begin
      n_fail++; $display("FAIL reset_rgb: rgb=%h, required 000000", {bus.oRed, bus.oGreen, bus.oBlue});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: in_ready=%b with empty pipe, required 1", bus.in_ready);
    end
  endtask

  task automatic test_latency(input string tag);
    bus.out_ready = 1'b1;
    set_px(0, 1023, 512);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_lat_ready: in_ready=%b, required 1", tag, bus.in_ready);
    end
    sb_q.push_back(pick(24'hFF0000, 24'hFF0101));
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== ((e == 3) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL %s_latency_edge%0d: out_valid=%b, required %b", tag, e, bus.out_valid, (e == 3));
      end
    end
    drain({tag, "_lat"});
  endtask

  task automatic test_colors();
    int h_tab [5] = '{0, 256, 512, 64, 800};
    logic [23:0] d_tab [5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF8000, 24'hFF4000};
    logic [23:0] r_tab [5] = '{24'hFF0101, 24'h01FF01, 24'h0101FF, 24'hFF8001, 24'hFF4001};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_px(h_tab[i], 1023, 512, pick(d_tab[i], r_tab[i]), "colors");
    drain("colors");
  endtask

  task automatic test_gray();
    int s_tab [4] = '{0, 1023, 1023, 0};
    int l_tab [4] = '{600, 1023, 0, 602};
    logic [23:0] d_tab [4] = '{24'h969696, 24'hFFFFFF, 24'h000000, 24'h969696};
    logic [23:0] r_tab [4] = '{24'h969696, 24'hFFFFFF, 24'h000000, 24'h979797};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_px(100, s_tab[i], l_tab[i], pick(d_tab[i], r_tab[i]), "gray");
    drain("gray");
  endtask

  task automatic test_back_to_back();
    int h, s, l;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      h = $urandom_range(0, 1023); s = $urandom_range(0, 1023); l = $urandom_range(0, 1023);
      set_px(h, s, l);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_in_ready: cycle %0d in_ready=%b, required 1", i, bus.in_ready);
      end else begin
        sb_q.push_back(model(h, s, l));
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain("b2b");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int rx0 = n_rx;
    logic [23:0] held;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      set_px(acc * 130, 900 - acc * 40, 300 + acc * 50);
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb_q.push_back(model(acc * 130, 900 - acc * 40, 300 + acc * 50));
        acc++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (acc != 3) begin
      n_fail++; $display("FAIL bp_accepts: %0d pixels accepted under stall, required 3", acc);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0/1", bus.in_ready, bus.out_valid);
    end
    held = {bus.oRed, bus.oGreen, bus.oBlue};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.oRed, bus.oGreen, bus.oBlue} !== held || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold: rgb=%h valid=%b, required %h valid=1", {bus.oRed, bus.oGreen, bus.oBlue}, bus.out_valid, held);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = acc; i < 6; i++) send_px(i * 130, 900 - i * 40, 300 + i * 50, model(i * 130, 900 - i * 40, 300 + i * 50), "bp");
    drain("bp");
    n_checks++;
    if (n_rx - rx0 != 6) begin
      n_fail++; $display("FAIL bp_count: %0d pixels delivered, required 6", n_rx - rx0);
    end
  endtask

  task automatic test_reset_in_flight();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_px(i * 200, 700, 400, model(i * 200, 700, 400), "rst");
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_inflight: out_valid=%b before reset, required 1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || {bus.oRed, bus.oGreen, bus.oBlue} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b rgb=%h, required 0/000000", bus.out_valid, {bus.oRed, bus.oGreen, bus.oBlue});
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_dropped: out_valid=%b after reset, required 0", bus.out_valid);
    end
    test_latency("post_rst");
  endtask

  task automatic test_random();
    int rx0 = n_rx;
    int h, s, l;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
          end
          h = $urandom_range(0, 1023); s = $urandom_range(0, 1023); l = $urandom_range(0, 1023);
          send_px(h, s, l, model(h, s, l), "random");
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("random");
    n_checks++;
    if (n_rx - rx0 != 10000) begin
      n_fail++; $display("FAIL random_count: %0d pixels delivered, required 10000", n_rx - rx0);
    end
  endtask

  initial begin
    test_reset();
    test_latency("first");
    test_colors();
    test_gray();
    test_back_to_back();
    test_backpressure();
    test_reset_in_flight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
